// File: rtl/cache_pkg.sv
// Shared types and geometry for the cache fill controller.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

  localparam int unsigned WORDS_PER_BLOCK = 8;
  localparam int unsigned NUM_SETS        = 64;
  localparam int unsigned TAG_W           = 6;
  localparam int unsigned INDEX_W         = 6;
  localparam int unsigned OFFSET_W        = 4;
  localparam int unsigned ADDR_W          = TAG_W + INDEX_W + OFFSET_W;

  // Tag-array entry layout: {tag, valid, lru}
  localparam int unsigned TAG_LRU_BIT     = 0;
  localparam int unsigned TAG_VALID_BIT   = 1;
  localparam int unsigned TAG_FIELD_LSB   = 2;
  localparam int unsigned TAG_ENTRY_W     = TAG_W + 2;

endpackage

// File: rtl/onehot_decoder.sv
// Binary-to-one-hot decoder with enable; all-zero output when disabled.
module onehot_decoder #(
  parameter int unsigned N = 3
) (
  input  logic              en,
  input  logic [N-1:0]      sel,
  output logic [(2**N)-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache block fill controller: issues eight word reads for a missed block and
// steers returning words and the final tag entry into the selected way.
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned WORDS   = 8,
  parameter int unsigned MEM_LAT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       miss_detected,
  input  logic [ADDR_W-1:0]          miss_address,
  input  logic                       victim_way,
  input  logic                       memory_data_valid,
  output logic                       mem_read_en,
  output logic [ADDR_W-1:0]          memory_address,
  output logic                       data_we,
  output logic                       tag_we,
  output logic                       way0_sel,
  output logic                       way1_sel,
  output logic [WORDS_PER_BLOCK-1:0] word_select,
  output logic [NUM_SETS-1:0]        set_enable,
  output logic [TAG_ENTRY_W-1:0]     tag_out,
  output logic                       fsm_busy,
  output logic                       fill_done
);

  localparam int unsigned ISSUE_W    = 4;
  localparam int unsigned WORD_IDX_W = $clog2(WORDS_PER_BLOCK);

  fill_state_e             state, state_nxt;
  logic [ISSUE_W-1:0]      issue_cnt, issue_cnt_nxt;
  logic [WORD_IDX_W-1:0]   recv_cnt, recv_cnt_nxt;
  logic [ADDR_W-1:0]       base, base_nxt;
  logic                    way, way_nxt;
  logic                    in_fill;
  logic                    word_rx;
  logic [INDEX_W-1:0]      set_idx;

  // Offset bits and the latency parameter carry no logic in the controller.
  logic unused_ok;
  assign unused_ok = ^{miss_address[OFFSET_W-1:0], (MEM_LAT != 0)};

  assign set_idx = base[OFFSET_W +: INDEX_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      base      <= '0;
      way       <= 1'b0;
    end else begin
      state     <= state_nxt;
      issue_cnt <= issue_cnt_nxt;
      recv_cnt  <= recv_cnt_nxt;
      base      <= base_nxt;
      way       <= way_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    issue_cnt_nxt  = issue_cnt;
    recv_cnt_nxt   = recv_cnt;
    base_nxt       = base;
    way_nxt        = way;
    mem_read_en    = 1'b0;
    memory_address = '0;
    data_we        = 1'b0;
    tag_we         = 1'b0;
    way0_sel       = 1'b0;
    way1_sel       = 1'b0;
    fsm_busy       = 1'b0;
    fill_done      = 1'b0;
    tag_out        = '0;

    // Reset also masks the decodes so nothing is written during the reset cycle.
    in_fill = !rst && (state == ST_FILL);
    // Returns before the first issued read cannot belong to this fill.
    word_rx = in_fill && memory_data_valid && (issue_cnt != '0);

    tag_out[TAG_FIELD_LSB +: TAG_W] = base[OFFSET_W + INDEX_W +: TAG_W];
    tag_out[TAG_VALID_BIT]          = 1'b1;
    tag_out[TAG_LRU_BIT]            = 1'b0;

    mem_read_en = in_fill && (issue_cnt < ISSUE_W'(WORDS));
    if (mem_read_en) memory_address = base + ADDR_W'({issue_cnt, 1'b0});
    data_we   = word_rx;
    tag_we    = word_rx && (recv_cnt == WORD_IDX_W'(WORDS - 1));
    way0_sel  = in_fill && !way;
    way1_sel  = in_fill && way;
    fsm_busy  = !rst && (state != ST_IDLE);
    fill_done = !rst && (state == ST_DONE);

    unique case (state)
      ST_IDLE: begin
        if (miss_detected) begin
          state_nxt     = ST_FILL;
          base_nxt      = {miss_address[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
          way_nxt       = victim_way;
          issue_cnt_nxt = '0;
          recv_cnt_nxt  = '0;
        end
      end
      ST_FILL: begin
        if (mem_read_en) issue_cnt_nxt = issue_cnt + ISSUE_W'(1);
        if (word_rx)     recv_cnt_nxt  = recv_cnt + WORD_IDX_W'(1);
        if (tag_we)      state_nxt     = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  onehot_decoder #(.N(WORD_IDX_W)) u_word_dec (
    .en     (word_rx),
    .sel    (recv_cnt),
    .onehot (word_select)
  );

  onehot_decoder #(.N(INDEX_W)) u_set_dec (
    .en     (in_fill),
    .sel    (set_idx),
    .onehot (set_enable)
  );

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl: latency-modelled memory, random stalls,
// and a transaction-level reference model of the fill sequence.
module tb_cache_fill_ctrl;

  localparam int unsigned MEM_LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        victim_way = 1'b0;
  logic        memory_data_valid = 1'b0;
  logic        mem_read_en, data_we, tag_we, way0_sel, way1_sel, fsm_busy, fill_done;
  logic [15:0] memory_address;
  logic [7:0]  word_select, tag_out;
  logic [63:0] set_enable;

  always #5 clk = ~clk;

  cache_fill_ctrl #(.WORDS(8), .MEM_LAT(MEM_LAT)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .victim_way        (victim_way),
    .memory_data_valid (memory_data_valid),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .data_we           (data_we),
    .tag_we            (tag_we),
    .way0_sel          (way0_sel),
    .way1_sel          (way1_sel),
    .word_select       (word_select),
    .set_enable        (set_enable),
    .tag_out           (tag_out),
    .fsm_busy          (fsm_busy),
    .fill_done         (fill_done)
  );

  int vectors = 0, miscompares = 0, cyc = 0;

  // Pending requester inputs, applied just after the next rising edge
  bit          p_rst = 1'b1, p_miss = 1'b0, p_way = 1'b0;
  logic [15:0] p_addr = '0;

  // Memory environment
  int stall_mode = 0, gap_cnt = 0;
  bit force_mdv = 1'b0;
  int memq[$];

  // Reference model: fill phase (0 idle, 1 filling, 2 done), reads issued, words taken
  int          m_mode = 0, m_issued = 0, m_recv = 0;
  logic [15:0] m_base = '0;
  bit          m_way = 1'b0;

  // Observations of the DUT for directed timing checks
  int          acc_cyc = 0, first_rd = -1, first_we = -1, last_we = -1;
  int          tagwe_cyc = -1, done_cyc = -1, words = 0, done_count = 0;
  bit          seen_done = 1'b0, both_sel = 1'b0;
  logic [7:0]  tag_at_we = '0;
  logic [63:0] set_seen = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic cycle();
    bit          fill, e_read, e_we, e_tagwe, ready;
    logic [15:0] e_addr;
    logic [63:0] e_word, e_set;
    @(posedge clk);
    #1;
    cyc++;
    rst           = p_rst;
    miss_detected = p_miss;
    miss_address  = p_addr;
    victim_way    = p_way;
    ready = (memq.size() > 0) && (memq[0] <= cyc);
    memory_data_valid = force_mdv;
    if (stall_mode == 1 && gap_cnt > 0) gap_cnt--;
    else if (ready && (stall_mode != 2 || $urandom_range(0, 1) == 1)) begin
      void'(memq.pop_front());
      memory_data_valid = 1'b1;
      if (stall_mode == 1) gap_cnt = 2;
    end
    @(negedge clk);

    fill    = !rst && m_mode == 1;
    e_read  = fill && m_issued < 8;
    e_addr  = e_read ? m_base + 16'(2 * m_issued) : 16'h0;
    e_we    = fill && memory_data_valid && m_issued > 0;
    e_word  = e_we ? (64'd1 << m_recv) : 64'd0;
    e_tagwe = e_we && m_recv == 7;
    e_set   = fill ? (64'd1 << m_base[9:4]) : 64'd0;

    chk("mem_read_en",    64'(mem_read_en),    64'(e_read));
    chk("memory_address", 64'(memory_address), 64'(e_addr));
    chk("data_we",        64'(data_we),        64'(e_we));
    chk("word_select",    64'(word_select),    e_word);
    chk("tag_we",         64'(tag_we),         64'(e_tagwe));
    chk("set_enable",     set_enable,          e_set);
    chk("way0_sel",       64'(way0_sel),       64'(fill && !m_way));
    chk("way1_sel",       64'(way1_sel),       64'(fill && m_way));
    chk("tag_out",        64'(tag_out),        64'({m_base[15:10], 2'b10}));
    chk("fsm_busy",       64'(fsm_busy),       64'(!rst && m_mode != 0));
    chk("fill_done",      64'(fill_done),      64'(!rst && m_mode == 2));

    if (mem_read_en) begin
      memq.push_back(cyc + int'(MEM_LAT));
      if (first_rd < 0) first_rd = cyc;
    end
    if (data_we) begin
      words++;
      last_we = cyc;
      if (first_we < 0) first_we = cyc;
    end
    if (tag_we) begin
      tagwe_cyc = cyc;
      tag_at_we = tag_out;
    end
    if (fill_done) begin
      seen_done = 1'b1;
      done_cyc  = cyc;
      done_count++;
    end
    if (set_enable != 64'd0) set_seen = set_enable;
    if (way0_sel && way1_sel) both_sel = 1'b1;

    if (rst) begin
      m_mode = 0; m_issued = 0; m_recv = 0; m_base = '0; m_way = 1'b0;
      memq.delete();
      gap_cnt = 0;
    end else begin
      case (m_mode)
        0: if (miss_detected) begin
          m_mode = 1; m_base = {miss_address[15:4], 4'h0}; m_way = victim_way;
          m_issued = 0; m_recv = 0; acc_cyc = cyc;
          first_rd = -1; first_we = -1; last_we = -1; tagwe_cyc = -1; done_cyc = -1;
          words = 0; seen_done = 1'b0; set_seen = '0;
        end
        1: begin
          m_issued += int'(e_read);
          m_recv   += int'(e_we);
          if (m_recv == 8) m_mode = 2;
        end
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic start_fill(input logic [15:0] addr, input bit way);
    p_miss = 1'b1;
    p_addr = addr;
    p_way  = way;
    cycle();
  endtask

  task automatic wait_done(input int budget, input bit toggle, input string tag);
    for (int i = 0; i < budget && !seen_done; i++) begin
      if (toggle) p_miss = 1'($urandom_range(0, 1));
      cycle();
    end
    chk(tag, 64'(seen_done), 64'd1);
    p_miss = 1'b0;
  endtask

  initial begin
    int w_before, d_before, d1;

    // Reset, then one idle cycle
    p_rst = 1'b1;
    repeat (3) cycle();
    p_rst = 1'b0;
    cycle();

    // Basic fill with zero-stall memory
    stall_mode = 0;
    start_fill(16'hABC6, 1'b1);
    wait_done(40, 1'b0, "basic_done_seen");
    chk("basic_first_read_cyc", 64'(first_rd - acc_cyc), 64'd1);
    chk("basic_first_we_cyc",   64'(first_we - acc_cyc), 64'd5);
    chk("basic_tag_we_cyc",     64'(tagwe_cyc - acc_cyc), 64'd12);
    chk("basic_done_cyc",       64'(done_cyc - acc_cyc), 64'd13);
    chk("basic_tag_value",      64'(tag_at_we), 64'h00AA);
    chk("basic_set_bit60",      set_seen, 64'd1 << 60);
    chk("basic_words",          64'(words), 64'd8);
    cycle();

    // Gapped memory: one return, then two idle cycles
    stall_mode = 1;
    start_fill(16'($urandom), 1'($urandom_range(0, 1)));
    wait_done(120, 1'b0, "gap_done_seen");
    chk("gap_words",        64'(words), 64'd8);
    chk("gap_done_after_we", 64'(done_cyc - last_we), 64'd1);
    stall_mode = 0;
    cycle();

    // Reset after three words have landed
    start_fill(16'h5A5A, 1'b0);
    for (int i = 0; i < 50 && words < 3; i++) cycle();
    chk("rst_words_before", 64'(words), 64'd3);
    p_miss = 1'b0;
    p_rst  = 1'b1;
    cycle();
    p_rst     = 1'b0;
    force_mdv = 1'b1;
    cycle();
    chk("rst_busy_after",    64'(fsm_busy), 64'd0);
    chk("rst_no_write_after", 64'(data_we), 64'd0);
    force_mdv = 1'b0;
    start_fill(16'h3F10, 1'b1);
    wait_done(40, 1'b0, "rst_refill_done_seen");
    chk("rst_refill_words", 64'(words), 64'd8);
    cycle();

    // Spurious data in IDLE, then miss_detected toggling mid-fill
    w_before  = words;
    force_mdv = 1'b1;
    repeat (3) cycle();
    force_mdv = 1'b0;
    chk("spur_idle_no_we", 64'(words), 64'(w_before));
    d_before = done_count;
    start_fill(16'hC3A0, 1'b0);
    wait_done(40, 1'b1, "spur_done_seen");
    repeat (3) cycle();
    chk("spur_single_fill", 64'(done_count - d_before), 64'd1);
    chk("spur_words",       64'(words), 64'd8);

    // Back-to-back misses to set 0, way 0 then way 1
    start_fill(16'h1C00, 1'b0);
    wait_done(40, 1'b0, "b2b_first_done_seen");
    d1 = done_cyc;
    p_miss = 1'b1;
    p_addr = 16'h2808;
    p_way  = 1'b1;
    cycle();
    wait_done(40, 1'b0, "b2b_second_done_seen");
    chk("b2b_second_first_read", 64'(first_rd - d1), 64'd2);
    chk("b2b_set0",              set_seen, 64'd1);
    chk("b2b_words",             64'(words), 64'd8);
    chk("b2b_way_exclusive",     64'(both_sel), 64'd0);
    cycle();

    // Random fills with random stall behaviour
    for (int n = 0; n < 6; n++) begin
      stall_mode = int'($urandom_range(0, 2));
      start_fill(16'($urandom), 1'($urandom_range(0, 1)));
      wait_done(150, 1'b0, "rand_done_seen");
      chk("rand_words", 64'(words), 64'd8);
      repeat (int'($urandom_range(1, 2))) cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_fill_ctrl.md
CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 The block SHALL have parameter WORDS, default 8, meaning words per cache block (fixed at 8 in this design).
REQ-002 The block SHALL have parameter MEM_LAT, default 4, meaning memory read latency in cycles (bench model only; the controller does not count latency).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port miss_detected, input, 1 bit: a cache miss is pending; held high by the requester until fill_done.
REQ-006 Port miss_address, input, 16 bits: byte address of the miss; fields are tag[15:10], index[9:4], offset[3:0].
REQ-007 Port victim_way, input, 1 bit: way to replace (0/1); sampled at miss start.
REQ-008 Port memory_data_valid, input, 1 bit: the memory returns one 16-bit word this cycle.
REQ-009 Port mem_read_en, output, 1 bit: issues one memory read this cycle.
REQ-010 Port memory_address, output, 16 bits: address of the issued read.
REQ-011 Port data_we, output, 1 bit: data-array write enable.
REQ-012 Port tag_we, output, 1 bit: tag-array write enable.
REQ-013 Ports way0_sel and way1_sel, outputs, 1 bit each: one-hot write-way select.
REQ-014 Port word_select, output, 8 bits: one-hot word enable.
REQ-015 Port set_enable, output, 64 bits: one-hot set enable.
REQ-016 Port tag_out, output, 8 bits: tag entry {tag[5:0], valid=1, lru=0}.
REQ-017 Port fsm_busy, output, 1 bit: a fill is in progress.
REQ-018 Port fill_done, output, 1 bit: single-cycle pulse marking fill completion.

Function
REQ-019 The FSM SHALL have three states, IDLE, FILL and DONE, with transitions as follows:
- IDLE to FILL when miss_detected=1.
- FILL to DONE in the cycle the 8th word is received.
- DONE to IDLE unconditionally.
REQ-020 On the IDLE-to-FILL transition, the block SHALL latch base = {miss_address[15:4], 4'h0} and victim_way.
REQ-021 In FILL, the block SHALL issue reads on consecutive cycles:
- mem_read_en=1 with memory_address = base + 2*issue_cnt;
- issue_cnt is a 4-bit counter running 0 to 8;
- issuing stops once issue_cnt=8.
REQ-022 In FILL, each cycle with memory_data_valid=1 SHALL produce:
- data_we=1;
- word_select = onehot(recv_cnt);
- recv_cnt (3 bits) incremented by one.
REQ-023 The receive that sets the 8th word (recv_cnt=7) SHALL also assert tag_we=1 in the same cycle.
REQ-024 way0_sel and way1_sel SHALL equal the decoded latched victim way in FILL and 0 otherwise.
REQ-025 set_enable SHALL equal onehot(base[9:4]) in FILL and 0 otherwise.
REQ-026 tag_out SHALL be {base[15:10], 1'b1, 1'b0} at all times.
REQ-027 fsm_busy SHALL be 1 in FILL and DONE, and 0 in IDLE.
REQ-028 fill_done SHALL be 1 only in DONE, lasting exactly one cycle.
REQ-029 memory_data_valid SHALL be ignored in IDLE and DONE, and when it arrives before any read has issued.
REQ-030 miss_detected SHALL be ignored while fsm_busy=1.
REQ-031 A new miss SHALL be accepted only from IDLE; the earliest acceptance is the cycle after DONE.
REQ-032 Back-to-back misses to the same set with a different victim_way SHALL each complete a full fill.
REQ-033 All outputs SHALL be registered-state decodes with no combinational path from miss_detected to any write enable.
REQ-034 With MEM_LAT=4 and a miss accepted at cycle 0:
- reads SHALL issue in cycles 1-8;
- data writes SHALL occur in cycles 5-12;
- fill_done SHALL assert in cycle 13.

Reset
REQ-035 While rst=1, the block SHALL force:
- state=IDLE;
- issue_cnt=0 and recv_cnt=0;
- base=0 and latched way=0;
- all enables, selects, set_enable and word_select = 0;
- fsm_busy=0 and fill_done=0.
REQ-036 A reset asserted mid-FILL SHALL abort the fill with no further data_we or tag_we; after release the block SHALL be in IDLE and accept a new miss.

Structure
REQ-037 Package cache_pkg SHALL hold:
- the state encoding;
- WORDS_PER_BLOCK=8, NUM_SETS=64, TAG_W=6, INDEX_W=6, OFFSET_W=4;
- the tag-entry bit positions.
REQ-038 A single sub-module, onehot_decoder (parameterised input width N, output 2^N), SHALL generate both word_select and set_enable.

Verification
REQ-039 Basic fill: miss_address=16'hABC6 with victim_way=1, MEM_LAT=4 SHALL produce:
- reads to 16'hABC0 through 16'hABCE in cycles 1-8;
- set_enable bit 60 and way1_sel during FILL;
- word_select 01 through 80 in cycles 5-12;
- tag_we with tag_out=8'hAA in cycle 12;
- fill_done in cycle 13.
REQ-040 Stalled memory: memory_data_valid gapped 1-on/2-off SHALL still write exactly 8 words in order, and fill_done SHALL follow the 8th word by one cycle.
REQ-041 Reset mid-fill: rst=1 after 3 words received SHALL give fsm_busy=0 and no writes in the next cycle; a following miss SHALL complete normally.
REQ-042 Spurious inputs: memory_data_valid=1 in IDLE and a miss_detected toggle during FILL SHALL cause no writes and no restart.
REQ-043 Back-to-back: two misses to set 0 with ways 0 then 1 SHALL give two fills, the second accepted the cycle after the first fill_done, and way selects SHALL never both be 1.
